// File: rtl/logic_gate_pipe.sv
// ============================================================================
// logic_gate_pipe
//   Bitwise OR/AND/XOR/NOR of two operands, results queued in a DEPTH-entry
//   FIFO with valid/ready handshakes on both sides.
//   Optional: `define LOGIC_GATE_PIPE_COUNT_EN adds the io_count pop counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_A,
  input  logic [WIDTH-1:0] io_B,
  input  logic [1:0]       io_mode,
  output logic             io_out_valid,
  input  logic             io_out_ready,
`ifdef LOGIC_GATE_PIPE_COUNT_EN
  output logic [15:0]      io_count,
`endif
  output logic [WIDTH-1:0] io_Y
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [1:0] c_MODE_OR  = 2'b00;
  localparam logic [1:0] c_MODE_AND = 2'b01;
  localparam logic [1:0] c_MODE_XOR = 2'b10;
  localparam logic [1:0] c_MODE_NOR = 2'b11;

  localparam logic [PTR_W-1:0] c_PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] w_result;
  logic             w_push;
  logic             w_pop;

  always_comb begin
    w_result = '0;
    case (io_mode)
      c_MODE_OR:  w_result = io_A | io_B;
      c_MODE_AND: w_result = io_A & io_B;
      c_MODE_XOR: w_result = io_A ^ io_B;
      c_MODE_NOR: w_result = ~(io_A | io_B);
      default:    w_result = '0;
    endcase
  end

  // Ready is gated by reset so nothing is accepted while reset is held high.
  assign io_in_ready  = ~reset & (r_count != c_CNT_FULL);
  assign io_out_valid = (r_count != '0);
  assign io_Y         = io_out_valid ? r_mem[r_rd_ptr] : '0;

  assign w_push = io_in_valid & io_in_ready;
  assign w_pop  = io_out_valid & io_out_ready;

  // Storage needs no reset: the head is masked whenever occupancy is zero.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_result;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef LOGIC_GATE_PIPE_COUNT_EN
  logic [15:0] r_pop_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pop_count <= '0;
    end else if (w_pop) begin
      r_pop_count <= r_pop_count + 16'd1;
    end
  end

  assign io_count = r_pop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_logic_gate_pipe.sv
// Directed self-checking bench for logic_gate_pipe (WIDTH=8, DEPTH=2).
`default_nettype none

module tb_logic_gate_pipe;

  logic       clock;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [7:0] io_A;
  logic [7:0] io_B;
  logic [1:0] io_mode;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [7:0] io_Y;
`ifdef LOGIC_GATE_PIPE_COUNT_EN
  logic [15:0] io_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic_gate_pipe #(.WIDTH(8), .DEPTH(2)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_A         (io_A),
    .io_B         (io_B),
    .io_mode      (io_mode),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
`ifdef LOGIC_GATE_PIPE_COUNT_EN
    .io_count     (io_count),
`endif
    .io_Y         (io_Y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, return at the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m, input logic rdy);
    io_in_valid  = v;
    io_A         = a;
    io_B         = b;
    io_mode      = m;
    io_out_ready = rdy;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b0);

    @(negedge clock);
    check("rst_in_ready", io_in_ready, 0);
    check("rst_out_valid", io_out_valid, 0);
    check("rst_Y", io_Y, 8'h00);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", io_in_ready, 1);
    check("post_rst_out_valid", io_out_valid, 0);
`ifdef LOGIC_GATE_PIPE_COUNT_EN
    check("rst_count", io_count, 16'd0);
`endif

    // Single OR beat
    @(negedge clock);
    drive(1'b1, 8'hA5, 8'h0F, 2'b00, 1'b1);
    step();
    check("or_valid", io_out_valid, 1);
    check("or_Y", io_Y, 8'hAF);
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    step();
    check("or_empty_valid", io_out_valid, 0);
    check("or_empty_Y", io_Y, 8'h00);

    // AND, XOR, NOR back-to-back with streaming output
    drive(1'b1, 8'hA5, 8'h0F, 2'b01, 1'b1);
    step();
    check("and_Y", io_Y, 8'h05);
    drive(1'b1, 8'hA5, 8'h0F, 2'b10, 1'b1);
    step();
    check("xor_Y", io_Y, 8'hAA);
    drive(1'b1, 8'hA5, 8'h0F, 2'b11, 1'b1);
    step();
    check("nor_Y", io_Y, 8'h50);
    check("nor_valid", io_out_valid, 1);
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    step();
    check("seq_empty_valid", io_out_valid, 0);

    // Fill to DEPTH with consumer stalled; third beat must be dropped
    drive(1'b1, 8'h11, 8'h00, 2'b10, 1'b0);
    step();
    check("fill1_in_ready", io_in_ready, 1);
    drive(1'b1, 8'h22, 8'h00, 2'b10, 1'b0);
    step();
    check("full_in_ready", io_in_ready, 0);
    check("full_head_Y", io_Y, 8'h11);
    drive(1'b1, 8'h33, 8'h00, 2'b10, 1'b0);
    step();
    check("full_hold_in_ready", io_in_ready, 0);
    check("full_hold_Y", io_Y, 8'h11);
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    step();
    check("drain1_Y", io_Y, 8'h22);
    check("drain1_in_ready", io_in_ready, 1);
    step();
    check("drain2_valid", io_out_valid, 0);

    // Occupancy 1 with 10 simultaneous push/pop cycles
    drive(1'b1, 8'h40, 8'h00, 2'b00, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      check("stream_Y", io_Y, 8'h40 + 8'(i));
      check("stream_in_ready", io_in_ready, 1);
      drive(1'b1, 8'h41 + 8'(i), 8'h00, 2'b00, 1'b1);
      step();
    end
    check("stream_last_Y", io_Y, 8'h4A);
    check("stream_last_valid", io_out_valid, 1);
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    step();
    check("stream_empty_valid", io_out_valid, 0);
`ifdef LOGIC_GATE_PIPE_COUNT_EN
    check("count_before_rst", io_count, 16'd17);
`endif

    // Reset mid-stream with two entries buffered
    drive(1'b1, 8'h5A, 8'h00, 2'b00, 1'b0);
    step();
    drive(1'b1, 8'h3C, 8'h00, 2'b00, 1'b0);
    step();
    check("pre_rst_valid", io_out_valid, 1);
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", io_out_valid, 0);
    check("midrst_Y", io_Y, 8'h00);
    check("midrst_in_ready", io_in_ready, 0);
`ifdef LOGIC_GATE_PIPE_COUNT_EN
    check("midrst_count", io_count, 16'd0);
`endif
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rel_in_ready", io_in_ready, 1);
    check("rel_valid", io_out_valid, 0);
    step();
    check("rel_no_stale", io_out_valid, 0);
    check("rel_no_stale_Y", io_Y, 8'h00);

    // NOR of all-zero operands sets every bit
    drive(1'b1, 8'h00, 8'h00, 2'b11, 1'b1);
    step();
    check("nor_zero_Y", io_Y, 8'hFF);
    drive(1'b0, 8'h00, 8'h00, 2'b00, 1'b1);
    step();
    check("final_empty", io_out_valid, 0);
`ifdef LOGIC_GATE_PIPE_COUNT_EN
    check("count_after_rst", io_count, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_gate_pipe.md
LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result bit width (1..64).
REQ-002 Parameter DEPTH, default 2, result buffer entries (2..8).
REQ-003 clock  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 io_in_valid  input  1  operand beat offered.
REQ-006 io_in_ready  output  1  block can accept an operand beat.
REQ-007 io_A  input  WIDTH  operand A.
REQ-008 io_B  input  WIDTH  operand B.
REQ-009 io_mode  input  2  op select, sampled with the operand beat: 00 OR, 01 AND, 10 XOR, 11 NOR.
REQ-010 io_out_valid  output  1  result at buffer head is valid.
REQ-011 io_out_ready  input  1  consumer accepts the result.
REQ-012 io_Y  output  WIDTH  result at buffer head.
REQ-013 io_count  output  16  completed-result counter (present only with the macro in REQ-031).

Function
REQ-014 Input beat is accepted on a cycle with io_in_valid=1 and io_in_ready=1 (push).
REQ-015 Result is popped on a cycle with io_out_valid=1 and io_out_ready=1 (pop).
REQ-016 Each push SHALL compute the bitwise op of io_A, io_B per io_mode and write it into a DEPTH-entry FIFO in the same edge.
REQ-017 Latency: result of a push at edge N SHALL appear on io_Y with io_out_valid=1 from edge N onward when the buffer was empty (one registered stage, no combinational path io_A->io_Y).
REQ-018 Results SHALL leave in push order; no reordering, no drop, no duplication.
REQ-019 io_in_ready = (occupancy < DEPTH); io_in_ready SHALL NOT depend combinationally on io_out_ready.
REQ-020 io_out_valid = (occupancy > 0); io_Y SHALL hold the head entry stable while io_out_valid=1 and io_out_ready=0.
REQ-021 Full: occupancy=DEPTH drives io_in_ready=0; offered beats are ignored, no state change.
REQ-022 Empty: occupancy=0 drives io_out_valid=0 and io_Y=0; io_out_ready ignored.
REQ-023 Simultaneous push and pop with 0<occupancy<DEPTH: occupancy unchanged, head advances, new entry appended.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH; occupancy counter width ceil(log2(DEPTH+1)).
REQ-025 io_mode changes between beats SHALL affect only subsequently pushed beats.
REQ-026 NOR result is the bitwise complement of OR across all WIDTH bits.

Reset
REQ-027 Assertion of reset SHALL immediately (asynchronously) clear occupancy and pointers, drive io_out_valid=0, io_Y=0, io_in_ready=0 while reset is high.
REQ-028 Buffered results at reset assertion SHALL be discarded, including mid-stream.
REQ-029 First cycle after reset deassertion: io_in_ready=1, io_out_valid=0.
REQ-030 io_count SHALL reset to 0.

Configuration
REQ-031 Macro LOGIC_GATE_PIPE_COUNT_EN: when defined, io_count exists and increments by 1 per pop, wrapping 0xFFFF->0x0000; when undefined, io_count port and counter logic are absent and all other behaviour is identical.

Verification
REQ-032 Reset then single push A=0xA5, B=0x0F, mode=00, out_ready=1 -> io_Y=0xAF, out_valid high one cycle, then empty.
REQ-033 Push A=0xA5, B=0x0F with modes 01,10,11 back-to-back, out_ready=1 -> io_Y sequence 0x05, 0xAA, 0x50 in order, one per cycle.
REQ-034 DEPTH=2, out_ready=0, push 3 beats -> io_in_ready=0 after 2nd push, 3rd beat ignored; release out_ready -> exactly 2 results emitted.
REQ-035 Occupancy 1, simultaneous push and pop for 10 cycles -> occupancy stays 1, all 10 results in order, pointers wrap correctly.
REQ-036 Reset asserted mid-stream with 2 entries buffered -> out_valid=0 and io_Y=0 immediately, no stale result after release.
REQ-037 With LOGIC_GATE_PIPE_COUNT_EN, preload 65535 pops then one more -> io_count=0x0000; build without macro elaborates with no io_count.
